// File: rtl/uart_pkg.sv
// Shared types for the UART frame parser: byte type, parser states,
// status pulse bundle and the running-checksum helper.
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CSUM,
        OUTPUT
    } parser_state_t;

    localparam byte_t SOF_DEFAULT = 8'h7E;

    typedef struct packed {
        logic frame_ok;
        logic err_len;
        logic err_csum;
        logic err_timeout;
        logic err_overrun;
    } status_t;

    function automatic byte_t xor_acc(byte_t acc, byte_t b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Payload stream leaving the frame parser: valid/ready byte handshake
// with end-of-frame marker and the frame length alongside.
interface uart_frame_parser_if;
    import uart_pkg::*;

    logic  m_valid;
    logic  m_ready;
    byte_t m_data;
    logic  m_last;
    byte_t m_len;

    modport master (output m_valid, m_data, m_last, m_len, input m_ready);
    modport slave  (input m_valid, m_data, m_last, m_len, output m_ready);

endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: one write port, combinational read port.
module uart_frame_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  byte_t         wdata,
    input  logic [AW-1:0] raddr,
    output byte_t         rdata
);
    byte_t mem [DEPTH];

    // NOTE: the array has no reset; every location is written before it is read.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame delineator behind uart_rx: collects SOF/LEN/PAYLOAD/CSUM frames,
// checks them and replays each good payload on a valid/ready stream.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int    BITS_PER_WORD = 8,
    parameter int    MAX_LEN       = 16,
    parameter byte_t SOF_BYTE      = SOF_DEFAULT,
    parameter int    TIMEOUT_CLKS  = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [BITS_PER_WORD-1:0] s_data,
    uart_frame_parser_if.master      m,
    output logic                     frame_ok,
    output logic                     err_len,
    output logic                     err_csum,
    output logic                     err_timeout,
    output logic                     err_overrun,
    output byte_t                    drop_cnt
);
    localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int            TW        = $clog2(TIMEOUT_CLKS + 1);
    localparam byte_t         MAX_LEN_B = byte_t'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

    parser_state_t state, state_n;
    byte_t         len, len_n, csum, csum_n, drop_n, rd_byte;
    logic [AW-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    status_t       status, status_n;
    logic          out_active, last_beat;

    uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (s_valid && (state == PAYLOAD)),
        .waddr (wr_ptr),
        .wdata (s_data),
        .raddr (rd_ptr),
        .rdata (rd_byte)
    );

    assign out_active = (state == OUTPUT);
    assign last_beat  = (byte_t'(rd_ptr) == len - 8'd1);

    // NOTE: every value written here gets a default first, so no latch is inferred.
    always_comb begin
        state_n  = state;
        len_n    = len;
        csum_n   = csum;
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        tmo_n    = '0;
        status_n = '0;
        drop_n   = drop_cnt;

        unique case (state)
            IDLE: if (s_valid && s_data == SOF_BYTE) state_n = LEN;
            LEN: if (s_valid) begin
                if (s_data == 8'd0 || s_data > MAX_LEN_B) begin
                    status_n.err_len = 1'b1;
                    state_n          = IDLE;
                end else begin
                    len_n    = s_data;
                    csum_n   = s_data;
                    wr_ptr_n = '0;
                    state_n  = PAYLOAD;
                end
            end
            PAYLOAD: if (s_valid) begin
                csum_n   = xor_acc(csum, s_data);
                wr_ptr_n = wr_ptr + AW'(1);
                if (byte_t'(wr_ptr) == len - 8'd1) state_n = CSUM;
            end
            CSUM: if (s_valid) begin
                if (s_data == csum) begin
                    status_n.frame_ok = 1'b1;
                    rd_ptr_n          = '0;
                    state_n           = OUTPUT;
                end else begin
                    status_n.err_csum = 1'b1;
                    state_n           = IDLE;
                end
            end
            OUTPUT: begin
                if (m.m_ready) begin
                    rd_ptr_n = rd_ptr + AW'(1);
                    if (last_beat) state_n = IDLE;
                end
                // No backpressure upstream: anything arriving now is lost.
                if (s_valid) begin
                    status_n.err_overrun = 1'b1;
                    if (drop_cnt != 8'hFF) drop_n = drop_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // An arriving byte always beats a timeout completing in the same cycle.
        if (state inside {LEN, PAYLOAD, CSUM} && !s_valid) begin
            if (tmo_cnt == TMO_LAST) begin
                status_n.err_timeout = 1'b1;
                state_n              = IDLE;
            end else begin
                tmo_n = tmo_cnt + TW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len      <= '0;
            csum     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tmo_cnt  <= '0;
            status   <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_n;
            len      <= len_n;
            csum     <= csum_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            tmo_cnt  <= tmo_n;
            status   <= status_n;
            drop_cnt <= drop_n;
        end
    end

    assign m.m_valid   = out_active;
    assign m.m_data    = out_active ? rd_byte : '0;
    assign m.m_last    = out_active && last_beat;
    assign m.m_len     = out_active ? len : '0;

    assign frame_ok    = status.frame_ok;
    assign err_len     = status.err_len;
    assign err_csum    = status.err_csum;
    assign err_timeout = status.err_timeout;
    assign err_overrun = status.err_overrun;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: frame-level reference model checked every
// cycle, directed scenarios with literal expectations, then random frames.
module tb_uart_frame_parser;
    import uart_pkg::*;

    localparam int    MAX_LEN      = 16;
    localparam int    TIMEOUT_CLKS = 60;
    localparam byte_t SOF          = 8'h7E;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  s_valid = 1'b0;
    byte_t s_data = '0;
    logic  frame_ok, err_len, err_csum, err_timeout, err_overrun;
    byte_t drop_cnt;

    uart_frame_parser_if m_if ();

    uart_frame_parser #(
        .BITS_PER_WORD (8),
        .MAX_LEN       (MAX_LEN),
        .SOF_BYTE      (SOF),
        .TIMEOUT_CLKS  (TIMEOUT_CLKS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .m           (m_if),
        .frame_ok    (frame_ok),
        .err_len     (err_len),
        .err_csum    (err_csum),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int    mdl_phase = 0;   // 0 hunting for SOF, 1 collecting frame, 2 delivering payload
    byte_t frame_q[$];      // LEN, payload..., CSUM as received
    byte_t out_q[$];        // payload still to be delivered
    byte_t exp_len = '0;
    int    idle_cnt = 0;
    int    exp_drop = 0;
    logic  exp_ok = 0, exp_elen = 0, exp_ecsum = 0, exp_etmo = 0, exp_eovr = 0;

    function automatic byte_t xor_all(input byte_t q[$]);
        byte_t x = '0;
        foreach (q[i]) x ^= q[i];
        return x;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            exp_ok = 0; exp_elen = 0; exp_ecsum = 0; exp_etmo = 0; exp_eovr = 0;
            if (rst) begin
                mdl_phase = 0; frame_q.delete(); out_q.delete();
                exp_len = '0; idle_cnt = 0; exp_drop = 0;
            end else if (mdl_phase == 0) begin
                if (s_valid && s_data == SOF) begin
                    mdl_phase = 1; frame_q.delete(); idle_cnt = 0;
                end
            end else if (mdl_phase == 1) begin
                if (s_valid) begin
                    idle_cnt = 0;
                    frame_q.push_back(s_data);
                    if (frame_q.size() == 1 && (s_data == 0 || int'(s_data) > MAX_LEN)) begin
                        exp_elen = 1; mdl_phase = 0;
                    end else if (frame_q.size() == int'(frame_q[0]) + 2) begin
                        // LEN ^ payload ^ CSUM is zero exactly when the checksum matches.
                        if (xor_all(frame_q) == 8'h00) begin
                            exp_ok = 1; exp_len = frame_q[0]; out_q.delete();
                            for (int i = 1; i < frame_q.size() - 1; i++) out_q.push_back(frame_q[i]);
                            mdl_phase = 2;
                        end else begin
                            exp_ecsum = 1; mdl_phase = 0;
                        end
                    end
                end else begin
                    idle_cnt++;
                    if (idle_cnt == TIMEOUT_CLKS) begin
                        exp_etmo = 1; mdl_phase = 0;
                    end
                end
            end else begin
                if (m_if.m_ready) begin
                    void'(out_q.pop_front());
                    if (out_q.size() == 0) mdl_phase = 0;
                end
                if (s_valid) begin
                    exp_eovr = 1;
                    if (exp_drop < 255) exp_drop++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("m_valid", m_if.m_valid, mdl_phase == 2);
            if (mdl_phase == 2 && out_q.size() > 0) begin
                check("m_data", m_if.m_data, out_q[0]);
                check("m_last", m_if.m_last, out_q.size() == 1);
                check("m_len", m_if.m_len, exp_len);
            end
            check("frame_ok", frame_ok, exp_ok);
            check("err_len", err_len, exp_elen);
            check("err_csum", err_csum, exp_ecsum);
            check("err_timeout", err_timeout, exp_etmo);
            check("err_overrun", err_overrun, exp_eovr);
            check("drop_cnt", drop_cnt, exp_drop);
        end
    end

    // ---------------- monitor: pulse counts and handshakes ----------------
    typedef struct {
        byte_t data;
        logic  last;
        byte_t len;
        int    cyc;
    } hs_t;

    hs_t hs_q[$];
    int  cnt_ok = 0, cnt_elen = 0, cnt_ecsum = 0, cnt_etmo = 0, cnt_eovr = 0, cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (frame_ok)    cnt_ok++;
            if (err_len)     cnt_elen++;
            if (err_csum)    cnt_ecsum++;
            if (err_timeout) cnt_etmo++;
            if (err_overrun) cnt_eovr++;
            if (m_if.m_valid && m_if.m_ready)
                hs_q.push_back('{m_if.m_data, m_if.m_last, m_if.m_len, cyc});
        end
    end

    // ---------------- m_ready driver ----------------
    int   rdy_mode = 0;   // 0 always ready, 1 random, 2 never, 3 scripted pattern
    int   pat_idx  = 0;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        m_if.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_if.m_ready = 1'b1;
                1: m_if.m_ready = ($urandom_range(0, 9) < 7);
                2: m_if.m_ready = 1'b0;
                default: begin
                    if (m_if.m_valid && pat_idx < 6) begin
                        m_if.m_ready = pat[pat_idx];
                        pat_idx++;
                    end else begin
                        m_if.m_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus helpers (all run at posedge + 1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic put(input byte_t b);
        s_valid = 1'b1;
        s_data  = b;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic send(input byte_t q[$], input int max_gap);
        foreach (q[i]) begin
            put(q[i]);
            if (i < q.size() - 1) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic wait_quiet(input int budget);
        int k = 0;
        while ((mdl_phase != 0 || m_if.m_valid) && k < budget) begin
            tick();
            k++;
        end
        check("drain_within_budget", k < budget, 1'b1);
        idle(2);
    endtask

    task automatic expect_frame(input string tag, input byte_t exp_q[$], input byte_t len);
        check({tag, "_handshakes"}, hs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
            check({tag, "_data"}, hs_q[i].data, exp_q[i]);
            check({tag, "_last"}, hs_q[i].last, i == exp_q.size() - 1);
            check({tag, "_len"}, hs_q[i].len, len);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, m_if.m_valid, 1'b0);
        check({tag, "_m_data"}, m_if.m_data, 8'h00);
        check({tag, "_m_last"}, m_if.m_last, 1'b0);
        check({tag, "_m_len"}, m_if.m_len, 8'h00);
        check({tag, "_pulses"}, {frame_ok, err_len, err_csum, err_timeout, err_overrun}, 5'b0);
        check({tag, "_drop_cnt"}, drop_cnt, 8'h00);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        byte_t q[$];
        byte_t e[$];
        int    ok0, elen0, ecsum0, etmo0, eovr0;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Good frame, always ready: 11,22,33 on consecutive cycles.
        hs_q.delete(); ok0 = cnt_ok;
        q = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send(q, 0);
        wait_quiet(100);
        e = '{8'h11, 8'h22, 8'h33};
        check("good_frame_ok", cnt_ok - ok0, 1);
        expect_frame("good", e, 8'd3);
        if (hs_q.size() == 3) begin
            check("good_consecutive_1", hs_q[1].cyc - hs_q[0].cyc, 1);
            check("good_consecutive_2", hs_q[2].cyc - hs_q[1].cyc, 1);
        end

        // Same frame under scripted backpressure.
        hs_q.delete(); pat_idx = 0; rdy_mode = 3;
        send(q, 0);
        wait_quiet(100);
        expect_frame("bp", e, 8'd3);
        rdy_mode = 0;

        // Length errors, checksum error, then a good frame.
        hs_q.delete(); elen0 = cnt_elen; ecsum0 = cnt_ecsum; ok0 = cnt_ok;
        q = '{8'h7E, 8'h00};                      send(q, 0); wait_quiet(50);
        q = '{8'h7E, 8'h11};                      send(q, 0); wait_quiet(50);
        check("len_err_count", cnt_elen - elen0, 2);
        q = '{8'h7E, 8'h02, 8'hAA, 8'hBB, 8'hFF}; send(q, 0); wait_quiet(50);
        check("csum_err_count", cnt_ecsum - ecsum0, 1);
        check("err_no_output", hs_q.size(), 0);
        q = '{8'h7E, 8'h01, 8'h5A, 8'h5B};        send(q, 0); wait_quiet(50);
        e = '{8'h5A};
        check("after_err_frame_ok", cnt_ok - ok0, 1);
        expect_frame("after_err", e, 8'd1);

        // Timeout, then junk and a good frame.
        hs_q.delete(); etmo0 = cnt_etmo; ok0 = cnt_ok;
        q = '{8'h7E, 8'h02, 8'hAA};
        send(q, 0);
        idle(TIMEOUT_CLKS + 2);
        check("timeout_count", cnt_etmo - etmo0, 1);
        q = '{8'h00, 8'hFF, 8'h7F, 8'h7E, 8'h01, 8'h42, 8'h43};
        send(q, 1);
        wait_quiet(50);
        e = '{8'h42};
        check("junk_frame_ok", cnt_ok - ok0, 1);
        expect_frame("junk", e, 8'd1);

        // Overrun: three bytes arrive while the 2-byte payload is stalled.
        hs_q.delete(); eovr0 = cnt_eovr; rdy_mode = 2;
        q = '{8'h7E, 8'h02, 8'h10, 8'h20, 8'h32};
        send(q, 0);
        put(8'h01); put(8'h02); put(8'h03);
        idle(1);
        check("overrun_pulses", cnt_eovr - eovr0, 3);
        check("overrun_drop_cnt", drop_cnt, 8'd3);
        rdy_mode = 0;
        wait_quiet(50);
        e = '{8'h10, 8'h20};
        expect_frame("overrun", e, 8'd2);

        // Reset in the middle of a payload, then a clean frame.
        q = '{8'h7E, 8'h04, 8'h01, 8'h02};
        send(q, 0);
        ok0 = cnt_ok; elen0 = cnt_elen; ecsum0 = cnt_ecsum; etmo0 = cnt_etmo; eovr0 = cnt_eovr;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        idle(3);
        @(negedge clk);
        rst = 1'b0;
        tick();
        idle(2);
        check("mid_reset_no_pulses",
              (cnt_ok - ok0) + (cnt_elen - elen0) + (cnt_ecsum - ecsum0) + (cnt_etmo - etmo0) + (cnt_eovr - eovr0), 0);
        hs_q.delete(); ok0 = cnt_ok;
        q = '{8'h7E, 8'h02, 8'hA5, 8'h3C, 8'h9B};
        send(q, 2);
        wait_quiet(50);
        e = '{8'hA5, 8'h3C};
        check("post_reset_frame_ok", cnt_ok - ok0, 1);
        expect_frame("post_reset", e, 8'd2);

        // Random frames checked against the model every cycle.
        for (int f = 0; f < 40; f++) begin
            int    kind;
            int    len;
            byte_t cs;
            byte_t b;
            kind     = $urandom_range(0, 9);
            len      = $urandom_range(1, MAX_LEN);
            rdy_mode = $urandom_range(0, 1);
            q.delete();
            q.push_back(SOF);
            if (kind == 7) begin
                if ($urandom_range(0, 1) == 1) q.push_back(8'h00);
                else q.push_back(byte_t'($urandom_range(MAX_LEN + 1, 255)));
                send(q, 3);
            end else if (kind == 9) begin
                q.push_back(byte_t'(len));
                send(q, 3);
                idle(TIMEOUT_CLKS + 3);
            end else begin
                q.push_back(byte_t'(len));
                cs = byte_t'(len);
                for (int j = 0; j < len; j++) begin
                    b = byte_t'($urandom_range(0, 255));
                    q.push_back(b);
                    cs ^= b;
                end
                if (kind == 8) cs ^= 8'h5A;
                q.push_back(cs);
                send(q, 3);
                repeat (2) if (m_if.m_valid) put(byte_t'($urandom_range(0, 255)));
            end
            wait_quiet(MAX_LEN * 40 + 100);
            repeat ($urandom_range(0, 2)) put(byte_t'($urandom_range(0, 8'h7D)));
        end
        rdy_mode = 0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, reached %0t, limit 5ms", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Byte-stream framer sitting directly downstream of uart_rx. It consumes the receiver's m_valid/m_data byte pulses and delineates frames of the form SOF, LEN, PAYLOAD[LEN], CSUM. It buffers and checks each frame, then replays the good payload on a valid/ready stream with a last marker. Error and drop status pulses go to the control/status logic.

Parameters:
BITS_PER_WORD, 8, byte width; the block supports only 8.
MAX_LEN, 16, maximum payload bytes per frame (2..255).
SOF_BYTE, 8'h7E, start-of-frame marker.
TIMEOUT_CLKS, 1000, idle clocks tolerated between bytes inside a frame.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
s_valid  in  1  one-cycle byte strobe from uart_rx m_valid; there is no backpressure
s_data  in  8  byte from uart_rx m_data
m_valid  out  1  payload byte available
m_ready  in  1  downstream accepts the byte
m_data  out  8  payload byte
m_last  out  1  high with the final payload byte of a frame
m_len  out  8  LEN of the frame being output; stable while m_valid is high
frame_ok  out  1  one-cycle pulse: frame passed all checks
err_len  out  1  one-cycle pulse: LEN is 0 or greater than MAX_LEN
err_csum  out  1  one-cycle pulse: checksum mismatch
err_timeout  out  1  one-cycle pulse: inter-byte timeout inside a frame
err_overrun  out  1  one-cycle pulse: byte dropped during OUTPUT
drop_cnt  out  8  saturating count of overrun-dropped bytes

Behaviour:
- Reset (async assert, sync deassert by the user): state IDLE; all outputs 0; drop_cnt 0; pointers 0. Asserting rst mid-frame or mid-output discards the frame with no status pulse.
- A byte is accepted on any rising clk edge with s_valid=1. Only the states below consume bytes.
- IDLE:
  - s_data==SOF_BYTE -> LEN.
  - Any other byte is ignored silently (not counted).
- LEN:
  - If the byte is 0 or greater than MAX_LEN: err_len pulses next cycle -> IDLE.
  - Otherwise latch len, csum=byte, wr_ptr=0 -> PAYLOAD.
- PAYLOAD:
  - Write buf[wr_ptr]; csum ^= byte; wr_ptr++.
  - After the len-th byte -> CSUM.
  - A SOF_BYTE value is ordinary data here; there is no byte stuffing.
- CSUM:
  - byte==csum: frame_ok pulses and m_valid rises in the next cycle (state OUTPUT, rd_ptr=0).
  - Mismatch: err_csum pulses next cycle -> IDLE.
  - Latency from checksum byte accepted to first m_valid: 1 cycle.
- OUTPUT:
  - m_data=buf[rd_ptr]; m_last=(rd_ptr==len-1); m_len=len.
  - m_valid/m_data/m_last hold stable until m_valid&&m_ready; each handshake advances rd_ptr.
  - The handshake with m_last -> IDLE, with m_valid low next cycle.
  - Any s_valid byte while in OUTPUT, including in the same cycle as the last handshake, is dropped: err_overrun pulses next cycle and drop_cnt increments, saturating at 255.
  - m_ready held high streams one byte per cycle.
- Timeout:
  - Counter cleared on every accepted byte and in IDLE/OUTPUT; counts in LEN/PAYLOAD/CSUM.
  - On reaching TIMEOUT_CLKS consecutive cycles without s_valid: err_timeout pulses and state -> IDLE.
  - If s_valid arrives in the same cycle the count completes, the byte wins and no timeout occurs.
- Checksum: 8-bit XOR of LEN and all payload bytes; SOF is excluded.
- At most one status pulse per cycle. err_overrun can only occur in OUTPUT, so it never coincides with the others.

Decomposition:
- uart_pkg holds:
  - typedef byte_t (logic [7:0]).
  - enum parser_state_t {IDLE, LEN, PAYLOAD, CSUM, OUTPUT}.
  - Localparam SOF_DEFAULT = 8'h7E.
  - Function xor_acc(byte_t acc, byte_t b).
- Sub-module uart_frame_buf: MAX_LEN x 8 register array with write port (we, waddr, wdata) and combinational read (raddr -> rdata). No reset on array contents.
- The parser owns the FSM, pointers, checksum, timeout counter and status logic.

Test Plan:
- Good frame: drive 7E,03,11,22,33,03 with m_ready=1 -> frame_ok once; m_data 11,22,33 on consecutive cycles; m_last on 33; m_len=3.
- Backpressure: same frame, m_ready toggled 1,0,0,1,0,1 -> m_data/m_last stable while stalled; exactly 3 handshakes; order 11,22,33.
- Errors:
  - 7E,00 -> err_len, no m_valid.
  - 7E,11 with MAX_LEN=16 -> err_len.
  - 7E,02,AA,BB,FF (expected csum 13) -> err_csum, no m_valid.
  - A following 7E,01,5A,5B -> frame_ok, m_data=5A.
- Timeout and junk: 7E,02,AA then TIMEOUT_CLKS idle clocks -> err_timeout; then junk 00,FF,7F followed by 7E,01,42,43 -> single frame_ok, m_data=42.
- Overrun: m_ready=0 during OUTPUT of a 2-byte frame while driving 3 bytes -> err_overrun x3, drop_cnt=3, frame data intact.
- Chain plus reset: uart_tx -> uart_rx -> parser with CLOCKS_PER_PULSE=10 sending 7E,02,A5,3C,9B -> m_data A5,3C, frame_ok. Assert rst mid-payload -> all outputs 0 immediately, no pulses; the next frame parses correctly.
